// File: rtl/frame_strobe_sequencer.sv
// Frame-write sequencer for one fabric column: takes (frame, data) commands and drives FrameData
// plus a registered one-hot FrameStrobe with programmable setup / strobe / hold timing.
module frame_strobe_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 1,
  parameter int HOLD_CYCLES     = 1
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [4:0]                 cmd_frame,
  input  logic [FrameBitsPerRow-1:0] cmd_data,
  input  logic                       err_clr,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err_addr,
  output logic [15:0]                frames_written
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // Timer reload values: a timed state lasts (reload + 1) cycles.
  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);
  localparam logic [5:0] FRAME_LIMIT = (MaxFramesPerCol > 32) ? 6'd32 : 6'(MaxFramesPerCol);

  state_t                     state;
  logic [7:0]                 timer;
  logic [4:0]                 frame_idx;
  logic [MaxFramesPerCol-1:0] strobe_sel;
  logic                       accept;
  logic                       frame_ok;
  logic                       timer_done;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign frame_ok   = ({1'b0, cmd_frame} < FRAME_LIMIT);
  assign timer_done = (timer == 8'd0);

  // One-hot decode of the latched index; lines beyond the 5-bit index range can never be selected.
  genvar gi;
  generate
    for (gi = 0; gi < MaxFramesPerCol; gi++) begin : g_sel
      if (gi < 32) begin : g_reach
        assign strobe_sel[gi] = (frame_idx == 5'(gi));
      end else begin : g_unreach
        assign strobe_sel[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      timer          <= 8'd0;
      frame_idx      <= 5'd0;
      FrameData      <= '0;
      FrameStrobe    <= '0;
      err_addr       <= 1'b0;
      frames_written <= 16'd0;
    end else begin
      // A new address error outranks a simultaneous clear.
      if (accept && !frame_ok) begin
        err_addr <= 1'b1;
      end else if (err_clr) begin
        err_addr <= 1'b0;
      end

      case (state)
        IDLE: begin
          FrameStrobe <= '0;
          if (accept && frame_ok) begin
            FrameData <= cmd_data;
            frame_idx <= cmd_frame;
            timer     <= SETUP_LOAD;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (timer_done) begin
            FrameStrobe <= strobe_sel;
            timer       <= STROBE_LOAD;
            state       <= STROBE;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        STROBE: begin
          if (timer_done) begin
            FrameStrobe    <= '0;
            frames_written <= frames_written + 16'd1;
            timer          <= HOLD_LOAD;
            state          <= HOLD;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        HOLD: begin
          FrameStrobe <= '0;
          if (timer_done) begin
            state <= IDLE;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: begin
          FrameStrobe <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
